conv_mac_pipe: RTL and testbench

Pipelined, parametrised K×K signed convolution MAC with valid/ready handshake and multi-channel accumulation. Each accepted beat is one K×K window plus kernel from one input channel. CHANNELS consecutive beats are accumulated with a bias and produce one fixed-point output. The output is rounded, saturated and optionally ReLU'd. It is the next-generation conv core: it replaces the single-cycle 3×3 unsigned unit and feeds the pooling/line-buffer stages downstream.

---
 rtl/conv_pkg.sv | 56 +++++
 rtl/conv_mac_pipe_adder_tree.sv | 21 ++
 rtl/conv_mac_pipe.sv | 139 +++++++++++++
 tb/tb_conv_mac_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, helpers and output post-processing for the convolution MAC.
package conv_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic signed [MAX_W-1:0] data;
    logic                    ovf;
  } post_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  function automatic int sum_w(input int width, input int taps);
    return prod_w(width) + clog2(taps);
  endfunction

  function automatic int acc_w(input int width, input int taps, input int channels);
    return sum_w(width, taps) + clog2(channels) + 1;
  endfunction

  // Round half up, drop FRAC bits, saturate to WIDTH, then optional ReLU.
  // ovf reports clipping and survives the ReLU clamp.
  function automatic post_t post_proc(input logic signed [MAX_W-1:0] acc,
                                      input int width, input int frac,
                                      input logic relu);
    post_t r;
    logic signed [MAX_W-1:0] v;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    v = acc;
    if (frac > 0) v = (v + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    r.ovf = 1'b0;
    if (v > hi) begin
      v = hi;
      r.ovf = 1'b1;
    end else if (v < lo) begin
      v = lo;
      r.ovf = 1'b1;
    end
    if (relu && (v < 0)) v = '0;
    r.data = v;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_pipe_adder_tree.sv
// Combinational signed sum of N packed terms, widened so it can never overflow.
module adder_tree_pipe
  import conv_pkg::*;
#(
  parameter int N     = 9,
  parameter int IN_W  = 18,
  parameter int OUT_W = IN_W + clog2(N)
) (
  input  logic [N*IN_W-1:0]       terms,
  output logic signed [OUT_W-1:0] sum
);

  // Sign-extend every term to the full output width and add them up.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + OUT_W'($signed(terms[i*IN_W +: IN_W]));
    end
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined KxK signed convolution MAC: products (S1), tree sum (S2),
// per-channel accumulation plus rounded/saturated output register (S3).
// A result appears three cycles after the cycle its last-channel beat is presented.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int K        = 3,
  parameter int CHANNELS = 4,
  parameter int FRAC     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [K*K*WIDTH-1:0]      win,
  input  logic [K*K*WIDTH-1:0]      ker,
  input  logic signed [WIDTH-1:0]   bias,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_data,
  output logic                      out_ovf
);

  localparam int TAPS   = K * K;
  localparam int PROD_W = prod_w(WIDTH);
  localparam int SUM_W  = sum_w(WIDTH, TAPS);
  localparam int ACC_W  = acc_w(WIDTH, TAPS, CHANNELS);
  localparam int CHAN_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

  logic en;

  logic [TAPS*PROD_W-1:0]   prod_c;
  logic [TAPS*PROD_W-1:0]   s1_prod;
  logic                     s1_valid;
  logic signed [WIDTH-1:0]  s1_bias;
  logic                     s1_relu;

  logic signed [SUM_W-1:0]  tree_sum;
  logic signed [SUM_W-1:0]  s2_sum;
  logic                     s2_valid;
  logic signed [WIDTH-1:0]  s2_bias;
  logic                     s2_relu;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_next;
  logic [CHAN_W-1:0]        chan;
  post_t                    post_res;
  logic                     unused_post_bits;

  // Whole pipe freezes only while a finished result waits on downstream.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  for (genvar t = 0; t < TAPS; t++) begin : g_mul
    assign prod_c[t*PROD_W +: PROD_W] =
      PROD_W'($signed(win[t*WIDTH +: WIDTH])) * PROD_W'($signed(ker[t*WIDTH +: WIDTH]));
  end

  adder_tree_pipe #(
    .N    (TAPS),
    .IN_W (PROD_W),
    .OUT_W(SUM_W)
  ) u_tree (
    .terms(s1_prod),
    .sum  (tree_sum)
  );

  // Channel 0 restarts from the scaled bias, later channels add to the running sum.
  always_comb begin
    acc_base = (chan == '0) ? (ACC_W'(s2_bias) <<< FRAC) : acc;
    acc_next = acc_base + ACC_W'(s2_sum);
    post_res = post_proc(MAX_W'(acc_next), WIDTH, FRAC, s2_relu);
  end

  assign unused_post_bits = ^post_res.data[MAX_W-1:WIDTH];

  // S1: register the tap products together with the beat's bias and ReLU flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
      s1_relu  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_prod  <= prod_c;
      s1_bias  <= bias;
      s1_relu  <= relu_en;
    end
  end

  // S2: register the adder-tree sum, still carrying bias and ReLU alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_bias  <= '0;
      s2_relu  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sum   <= tree_sum;
      s2_bias  <= s1_bias;
      s2_relu  <= s1_relu;
    end
  end

  // S3: accumulate valid beats and step the channel counter; bubbles leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc  <= '0;
      chan <= '0;
    end else if (en && s2_valid) begin
      acc  <= acc_next;
      chan <= (chan == LAST_CHAN) ? '0 : chan + 1'b1;
    end
  end

  // Output register: load on the last channel, otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (s2_valid && (chan == LAST_CHAN)) begin
        out_valid <= 1'b1;
        out_data  <= post_res.data[WIDTH-1:0];
        out_ovf   <= post_res.ovf;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed, table-driven bench for conv_mac_pipe with WIDTH=9, K=3, CHANNELS=2, FRAC=4.
module tb_conv_mac_pipe;

  localparam int W    = 9;
  localparam int K    = 3;
  localparam int CH   = 2;
  localparam int FRAC = 4;
  localparam int TAPS = K * K;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [TAPS*W-1:0]     win;
  logic [TAPS*W-1:0]     ker;
  logic signed [W-1:0]   bias;
  logic                  relu_en;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [W-1:0]   out_data;
  logic                  out_ovf;

  int checks;
  int errors;

  typedef struct {
    string name;
    int    w0a, w0c, k0a, k0c;
    int    w1a, w1c, k1a, k1c;
    int    bias;
    logic  relu;
    int    gap;
    int    exp_data;
    logic  exp_ovf;
  } vec_t;

  vec_t vecs[11];

  conv_mac_pipe #(
    .WIDTH(W), .K(K), .CHANNELS(CH), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .win(win), .ker(ker), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(string name, int w0a, int w0c, int k0a, int k0c,
                                 int w1a, int w1c, int k1a, int k1c, int b,
                                 logic relu, int gap, int ed, logic eo);
    vec_t v;
    v.name = name;
    v.w0a = w0a; v.w0c = w0c; v.k0a = k0a; v.k0c = k0c;
    v.w1a = w1a; v.w1c = w1c; v.k1a = k1a; v.k1c = k1c;
    v.bias = b; v.relu = relu; v.gap = gap; v.exp_data = ed; v.exp_ovf = eo;
    return v;
  endfunction

  // All taps set to 'all' except the centre tap, which gets 'ctr'.
  function automatic logic [TAPS*W-1:0] mkTaps(int all, int ctr);
    logic [TAPS*W-1:0] v;
    for (int t = 0; t < TAPS; t++) v[t*W +: W] = (t == TAPS / 2) ? W'(ctr) : W'(all);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Channel 0 gets the inverse relu flag and channel 1 a junk bias: both must be ignored.
  task automatic driveBeat(input vec_t v, input int ch);
    in_valid = 1'b1;
    if (ch == 0) begin
      win = mkTaps(v.w0a, v.w0c);
      ker = mkTaps(v.k0a, v.k0c);
      bias = W'(v.bias);
      relu_en = ~v.relu;
    end else begin
      win = mkTaps(v.w1a, v.w1c);
      ker = mkTaps(v.k1a, v.k1c);
      bias = W'(77);
      relu_en = v.relu;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int ch);
    @(negedge clk);
    driveBeat(v, ch);
    @(posedge clk);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic checkOutput(input int exp_data, input logic exp_ovf, input string name);
    int   lat;
    logic found;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        found = 1'b1;
        lat = i;
      end
    end
    chk({name, "_arrived"}, int'(found), 1);
    if (found) begin
      chk({name, "_latency"}, lat, 3);
      chk({name, "_data"}, int'(out_data), exp_data);
      chk({name, "_ovf"}, int'(out_ovf), int'(exp_ovf));
      @(negedge clk);
      chk({name, "_valid_drop"}, int'(out_valid), 0);
    end
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v, 0);
    for (int g = 0; g < v.gap; g++) idleCycle();
    applyStimulus(v, 1);
    checkOutput(v.exp_data, v.exp_ovf, v.name);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t bp[4];
    int   bi;
    int   got;
    int   stall_left;
    logic seen_first;
    logic have_held;
    int   held;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    win = '0;
    ker = '0;
    bias = '0;
    relu_en = 1'b0;
    out_ready = 1'b1;

    //             name           w0a w0c  k0a  k0c  w1a  w1c k1a  k1c  bias  relu gap  exp  ovf
    vecs[0]  = mkVec("basic",      16, 16,   0,  16,  16,  16,  0,  16,   16, 1'b0, 0,   48, 1'b0);
    vecs[1]  = mkVec("sat_pos",    16, 16,  16,  16,  16,  16, 16,  16,    0, 1'b0, 0,  255, 1'b1);
    vecs[2]  = mkVec("sat_neg",    16, 16, -16, -16,  16,  16,-16, -16,    0, 1'b0, 1, -256, 1'b1);
    vecs[3]  = mkVec("relu_on",    16, 16,   0, -16,  16,  16,  0, -16,   16, 1'b1, 0,    0, 1'b0);
    vecs[4]  = mkVec("relu_off",   16, 16,   0, -16,  16,  16,  0, -16,   16, 1'b0, 0,  -16, 1'b0);
    vecs[5]  = mkVec("round_up",    0,  1,   0,   8,   0,   0,  0,   0,    0, 1'b0, 0,    1, 1'b0);
    vecs[6]  = mkVec("round_down",  0,  1,   0,   7,   0,   0,  0,   0,    0, 1'b0, 0,    0, 1'b0);
    vecs[7]  = mkVec("mixed_gap",  32, 32,   0,  -8, -16, -16,  4,   4,    5, 1'b0, 2,  -47, 1'b0);
    vecs[8]  = mkVec("sat_relu",   16, 16, -16, -16,  16,  16,-16, -16,    0, 1'b1, 0,    0, 1'b1);
    vecs[9]  = mkVec("max_exact",   0,  0,   0,   0,   0,   0,  0,   0,  255, 1'b0, 0,  255, 1'b0);
    vecs[10] = mkVec("min_exact",   0,  0,   0,   0,   0,   0,  0,   0, -256, 1'b0, 0, -256, 1'b0);

    doReset();

    for (int i = 0; i < 11; i++) runVector(vecs[i]);

    // Backpressure: 8 beats streamed, downstream stalls after the first result.
    $display("[TB] backpressure stream");
    bp[0] = vecs[0];
    bp[1] = vecs[1];
    bp[2] = vecs[3];
    bp[3] = vecs[7];
    bi = 0;
    got = 0;
    stall_left = 0;
    seen_first = 1'b0;
    have_held = 1'b0;
    held = 0;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk);
      if (seen_first && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_stall_in_ready", int'(in_ready), 0);
        if (have_held) chk("bp_stall_hold", int'(out_data), held);
        held = int'(out_data);
        have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_result%0d", got), int'(out_data), bp[got].exp_data);
        chk($sformatf("bp_ovf%0d", got), int'(out_ovf), int'(bp[got].exp_ovf));
        got++;
        if (!seen_first) begin
          seen_first = 1'b1;
          stall_left = 5;
        end
      end
      if (bi < 8) driveBeat(bp[bi / 2], bi % 2);
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) bi++;
    end
    chk("bp_results_count", got, 4);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset after channel 0 reached the accumulator; next pair must start fresh.
    $display("[TB] reset mid-accumulation");
    applyStimulus(vecs[1], 0);
    repeat (3) idleCycle();
    doReset();
    runVector(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
